// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg: shared definitions for the DAC SPI/LDAC controller.
// Holds the FSM state encoding, the Avalon-MM register word addresses,
// the STATUS/CTRL bit positions and the default DAC frame width.
package dac_spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LDAC  = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_TXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int STS_BUSY    = 0;
  localparam int STS_OVERRUN = 1;
  localparam int STS_DONE    = 2;

  localparam int CTRL_AUTO_LDAC = 0;
  localparam int CTRL_IRQ_EN    = 1;

endpackage

// File: rtl/dac_spi_tick_gen.sv
// dac_spi_tick_gen: half-period timebase for the DAC serial clock.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   clear        : holds the count at zero (asserted while the FSM idles)
//   tick         : high on the last cycle of every CLK_DIV-cycle interval
// Every state boundary after IDLE coincides with a tick, so the wrap on
// tick restarts the count exactly on entry to the next state or half-period.
module dac_spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  assign tick = (cnt_r == CNT_LAST);

  // Half-period counter: restart on clear or on reaching the last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear || tick) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/dac_spi_ldac_ctrl.sv
// dac_spi_ldac_ctrl: Avalon-MM slave that shifts one FRAME_BITS-wide frame
// MSB-first to a serial DAC and optionally pulses LDAC after each frame.
// Ports:
//   clk, reset_n                  : system clock, async active-low reset
//   address/chipselect/write_n/
//   writedata/readdata            : register interface (TXDATA, STATUS, CTRL)
//   ldac_n_pio                    : software LDAC request, active-low
//   dac_sclk/dac_sync_n/dac_sdin  : DAC serial port (sclk idles high)
//   dac_ldac_n                    : DAC load strobe, active-low
//   irq                           : STATUS.done AND CTRL.irq_en
module dac_spi_ldac_ctrl
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT,
  parameter int LDAC_PULSE = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        ldac_n_pio,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_sdin,
  output logic        dac_ldac_n,
  output logic        irq
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [3:0]    LDAC_LAST = 4'(LDAC_PULSE - 1);

  state_e                state_r;
  logic                  sclk_r, sync_n_r, sdin_r, ldac_int_r;
  logic [FRAME_BITS-1:0] shift_r, txdata_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [3:0]            ldac_cnt_r;
  logic                  done_r, overrun_r;
  logic [1:0]            ctrl_r;

  logic tick_s, tick_clr_s, busy_s, wr_s, tx_wr_s, sts_wr_s, ctrl_wr_s;
  logic start_s, hold_exit_s, ldac_exit_s, done_set_s, unused_wdata_s;

  assign wr_s        = chipselect && !write_n;
  assign tx_wr_s     = wr_s && (address == ADDR_TXDATA);
  assign sts_wr_s    = wr_s && (address == ADDR_STATUS);
  assign ctrl_wr_s   = wr_s && (address == ADDR_CTRL);
  assign busy_s      = (state_r != ST_IDLE);
  assign start_s     = tx_wr_s && !busy_s;
  assign hold_exit_s = (state_r == ST_HOLD) && tick_s;
  assign ldac_exit_s = (state_r == ST_LDAC) && (ldac_cnt_r == LDAC_LAST);
  // done rises on the same edge the FSM returns to IDLE
  assign done_set_s  = (hold_exit_s && !ctrl_r[CTRL_AUTO_LDAC]) || ldac_exit_s;
  assign tick_clr_s  = (state_r == ST_IDLE);
  // upper writedata bits carry no meaning for any register
  assign unused_wdata_s = ^writedata;

  dac_spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clr_s),
    .tick    (tick_s)
  );

  // Frame sequencer: drives the serial pins and the internal LDAC strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      sclk_r     <= 1'b1;
      sync_n_r   <= 1'b1;
      sdin_r     <= 1'b0;
      ldac_int_r <= 1'b1;
      shift_r    <= {FRAME_BITS{1'b0}};
      bit_cnt_r  <= {BW{1'b0}};
      ldac_cnt_r <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r  <= ST_SETUP;
            sync_n_r <= 1'b0;
            sclk_r   <= 1'b1;
            shift_r  <= writedata[FRAME_BITS-1:0];
            sdin_r   <= writedata[FRAME_BITS-1];
          end
        end
        ST_SETUP: begin
          if (tick_s) begin
            state_r   <= ST_SHIFT;
            sclk_r    <= 1'b0;
            bit_cnt_r <= {BW{1'b0}};
          end
        end
        ST_SHIFT: begin
          if (tick_s) begin
            if (!sclk_r) begin
              // rising edge: present the next bit; DAC samples on the fall
              sclk_r <= 1'b1;
              if (bit_cnt_r != BIT_LAST) begin
                sdin_r  <= shift_r[FRAME_BITS-2];
                shift_r <= shift_r << 1;
              end
            end else if (bit_cnt_r == BIT_LAST) begin
              state_r  <= ST_HOLD;
              sync_n_r <= 1'b1;
            end else begin
              sclk_r    <= 1'b0;
              bit_cnt_r <= bit_cnt_r + BW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            if (ctrl_r[CTRL_AUTO_LDAC]) begin
              state_r    <= ST_LDAC;
              ldac_int_r <= 1'b0;
              ldac_cnt_r <= 4'd0;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_LDAC: begin
          if (ldac_exit_s) begin
            state_r    <= ST_IDLE;
            ldac_int_r <= 1'b1;
          end else begin
            ldac_cnt_r <= ldac_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          sclk_r     <= 1'b1;
          sync_n_r   <= 1'b1;
          ldac_int_r <= 1'b1;
        end
      endcase
    end
  end

  // Register file: TXDATA readback, CTRL, and STATUS with set-wins W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txdata_r  <= {FRAME_BITS{1'b0}};
      ctrl_r    <= 2'b00;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (start_s) begin
        txdata_r <= writedata[FRAME_BITS-1:0];
      end
      if (ctrl_wr_s) begin
        ctrl_r <= writedata[1:0];
      end
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (start_s || (sts_wr_s && writedata[STS_DONE])) begin
        done_r <= 1'b0;
      end
      if (tx_wr_s && busy_s) begin
        overrun_r <= 1'b1;
      end else if (sts_wr_s && writedata[STS_OVERRUN]) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Zero-wait read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_TXDATA: readdata[FRAME_BITS-1:0] = txdata_r;
      ADDR_STATUS: readdata = {29'd0, done_r, overrun_r, busy_s};
      ADDR_CTRL:   readdata = {30'd0, ctrl_r};
      ADDR_RSVD:   readdata = 32'd0;
      default:     readdata = 32'd0;
    endcase
  end

  assign dac_sclk   = sclk_r;
  assign dac_sync_n = sync_n_r;
  assign dac_sdin   = sdin_r;
  assign dac_ldac_n = ldac_n_pio & ldac_int_r;
  assign irq        = done_r & ctrl_r[CTRL_IRQ_EN];

endmodule

// File: doc/dac_spi_ldac_ctrl.md
DAC_SPI_LDAC_CTRL -- requirements
Module: dac_spi_ldac_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter FRAME_BITS, default 24: bits per DAC frame, sent MSB first.
REQ-003 Parameter LDAC_PULSE, default 2: auto-LDAC low width in clk cycles; legal range 1..15.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 address  in  2  Avalon-MM slave word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data; combinational from address, zero-wait.
REQ-011 ldac_n_pio  in  1  software LDAC request from the PIO stage, active-low.
REQ-012 dac_sclk  out  1  DAC serial clock; idles high.
REQ-013 dac_sync_n  out  1  DAC frame select, active-low.
REQ-014 dac_sdin  out  1  DAC serial data.
REQ-015 dac_ldac_n  out  1  DAC load strobe, active-low.
REQ-016 irq  out  1  high while STATUS.done=1 and CTRL.irq_en=1.

Function
REQ-017 Register map: addr0 TXDATA (W: frame[FRAME_BITS-1:0]; R: last frame written); addr1 STATUS (R: bit0 busy, bit1 overrun, bit2 done; W1C on bits1-2); addr2 CTRL (R/W: bit0 auto_ldac, bit1 irq_en); addr3 reads 0, writes ignored.
REQ-018 A write is a cycle with chipselect=1 and write_n=0; unused writedata bits are ignored; unused readdata bits read 0.
REQ-019 FSM states: IDLE, SETUP, SHIFT, HOLD, LDAC.
REQ-020 IDLE + TXDATA write: latch frame, clear done, enter SETUP on the next cycle; dac_sync_n=0 and dac_sdin=frame MSB from that cycle on.
REQ-021 SETUP lasts CLK_DIV cycles with dac_sclk=1, then enters SHIFT.
REQ-022 SHIFT, per bit: dac_sclk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles; dac_sdin changes only on the cycle dac_sclk rises; the DAC samples on the falling edge.
REQ-023 After FRAME_BITS bits (2*FRAME_BITS*CLK_DIV cycles), dac_sync_n=1 and the FSM enters HOLD.
REQ-024 HOLD lasts CLK_DIV cycles; exit to LDAC if auto_ldac=1, otherwise to IDLE.
REQ-025 LDAC drives the internal ldac low for LDAC_PULSE cycles, then enters IDLE.
REQ-026 dac_ldac_n = ldac_n_pio AND internal ldac, combinational; either source asserts the strobe.
REQ-027 busy=1 in every state except IDLE; done is set on the cycle the FSM enters IDLE from HOLD or LDAC.
REQ-028 A TXDATA write while busy=1 is dropped, sets overrun, and leaves the frame in flight unchanged.
REQ-029 A STATUS W1C in the same cycle as a done or overrun set event resolves as set-wins.
REQ-030 A CTRL write while busy=1 takes effect; auto_ldac is sampled on HOLD exit.
REQ-031 Bit and half-period counters are sized from the parameters and wrap only through state exit.

Reset
REQ-032 Asserting reset_n, including mid-frame, aborts any transfer immediately; the FSM enters IDLE.
REQ-033 Reset values: dac_sclk=1, dac_sync_n=1, dac_sdin=0, internal ldac=1; TXDATA, STATUS and CTRL all 0, so irq=0.
REQ-034 Release from reset is synchronous to clk; the first transfer may start on the first write after release.

Structure
REQ-035 Package dac_spi_pkg holds the FSM state enum, register address constants, STATUS/CTRL bit indices and the FRAME_BITS default.
REQ-036 One sub-module, dac_spi_tick_gen: a CLK_DIV half-period tick counter, cleared on state entry.
REQ-037 All registers live in a single clock domain; ldac_n_pio is already synchronous to clk and is not resynchronised.

Verification
REQ-038 CLK_DIV=4, write TXDATA=0x00ABCDEF -> 24 falling dac_sclk edges capture 0xABCDEF MSB first; dac_sync_n low for exactly 4+192 cycles; done=1 afterwards.
REQ-039 auto_ldac=1, write 0x123456 -> dac_ldac_n low for exactly 2 cycles, starting 4 cycles after dac_sync_n rises; busy falls on the next cycle.
REQ-040 Second TXDATA write 10 cycles into a frame -> overrun=1; the shifted data still equals the first frame; W1C to STATUS bit1 clears overrun.
REQ-041 ldac_n_pio=0 while auto_ldac=0 and the FSM is IDLE -> dac_ldac_n=0 on the same cycle; ldac_n_pio=1 -> dac_ldac_n returns to 1.
REQ-042 reset_n asserted mid-SHIFT -> outputs take their REQ-033 reset values immediately; a new write after release produces a clean full frame.
REQ-043 irq_en=1 -> irq rises with done; W1C to STATUS bit2 drops irq; a W1C coinciding with a new done event leaves done=1.
